flag_unit: RTL and testbench
============================

# flag_unit

Flag register and branch-condition resolver for the WISC execute stage. Sits directly downstream of `addsub_16bit` and the rest of the ALU: captures the `[N V Z]` flag vector, applies the per-opcode update mask, and resolves conditional branches against the architectural flags. Produces a registered taken/not-taken decision one cycle after a branch is presented. Optionally forwards same-cycle flag updates.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `alu_valid`  in  1  — ALU result present this cycle.
- `alu_op`  in  4  — opcode of the ALU instruction.
- `alu_flag`  in  3  — ALU flag vector `[N V Z]` (bit2=N, bit1=V, bit0=Z).
- `br_valid`  in  1  — branch presented this cycle.
- `br_cond`  in  3  — branch condition code.
- `stall`  in  1  — pipeline stall; freezes all state.
- `flush`  in  1  — squash the ALU update and branch of this cycle.
- `flag`  out  3  — architectural flags `[N V Z]`.
- `br_resolved`  out  1  — registered; branch resolved last cycle.
- `br_taken`  out  1  — registered; valid only while `br_resolved`=1.
- `br_hazard`  out  1  — combinational; branch cannot resolve this cycle, upstream must re-present it.

## Operation
- Update mask by `alu_op`: 0000 ADD, 0001 SUB → write N, V, Z; 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR → write Z only; all other opcodes → no write.
- Flag write occurs when `alu_valid & ~stall & ~flush` and mask non-zero; unmasked bits hold.
- `next_flag` = masked merge of `alu_flag` into `flag` (equals `flag` when no write).
- Branch conditions (evaluated on flag source F):
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OVFL: V=1
  - 111 UNCOND: always taken
- Branch accepted when `br_valid & ~stall & ~flush & ~br_hazard`; on acceptance, register `br_resolved`=1 and `br_taken`=cond(F).
- In any non-accepting cycle, `br_resolved` clears to 0 next edge; `br_taken` clears to 0.
- Source F and hazard depend on configuration (below).
- Branch alone never alters flags. A same-cycle ALU op is older than the branch.

## Timing
- Reset (async, immediate): `flag`=000, `br_resolved`=0, `br_taken`=0. `br_hazard` follows inputs combinationally.
- Flag latency: one cycle; `flag` shows update after the edge following `alu_valid`.
- Branch latency: one cycle from accepted `br_valid` to `br_resolved`=1.
- `stall`=1: `flag` holds; `br_resolved` and `br_taken` clear; `br_hazard` forced 0.
- `flush`=1: same as stall for that cycle's inputs; flags hold.
- `stall` and `flush` together behave as `flush`.
- Back-to-back branches: resolve on consecutive cycles, one per cycle.
- Reset asserted mid-branch drops the pending resolution; no `br_resolved` pulse after reset release.

## Configuration
- `FLAG_BYPASS_EN` defined: F = `next_flag`; a branch in the same cycle as a flag-writing ALU op sees the new flags; `br_hazard` is tied 0.
- Not defined: F = registered `flag`. `br_hazard`=1 when `br_valid & alu_valid & ~stall & ~flush` and the mask is non-zero. The branch is not accepted, and upstream re-presents it the next cycle against the updated flags.

## Test plan
- Reset: `rst` pulse mid-cycle → `flag`=000, `br_resolved`=0 immediately, without a clock edge.
- SUB with `alu_flag`=110 (0x8000−0x0001 saturating), then EQ next cycle → `flag`=110, `br_resolved`=1, `br_taken`=0. OVFL under the same flags → `br_taken`=1.
- `flag`=110, XOR with `alu_flag`=001 → `flag`=111, with only Z written. Then op 0111 with `alu_flag`=000 → `flag` unchanged at 111.
- ADD `alu_flag`=001 and EQ in the same cycle, starting from `flag`=000:
  - With `FLAG_BYPASS_EN`: `br_taken`=1 after one cycle.
  - Without: `br_hazard`=1 that cycle; re-presented EQ resolves taken one cycle later.
- `stall`=1 with SUB `alu_flag`=100 and GT → `flag` holds, `br_resolved`=0. Same inputs after stall release → `flag`=100, GT not taken.
- `flush`=1 with ADD and UNCOND → no flag change, no `br_resolved`. UNCOND the next cycle → `br_taken`=1.

Source files
------------

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
//
// Flag register and branch-condition resolver for the WISC execute stage.
// Captures the ALU flag vector [N V Z] under a per-opcode write mask and
// resolves conditional branches, producing a registered taken/not-taken
// decision one cycle after the branch is accepted.
//
// Optional feature macro: FLAG_BYPASS_EN
//   defined   : branches evaluate against next_flag (same-cycle ALU update is
//               forwarded); br_hazard is tied low.
//   undefined : branches evaluate against the registered flags; a branch that
//               coincides with a flag-writing ALU op raises br_hazard and must
//               be re-presented by upstream on the following cycle.
//
// Ports:
//   clk          in  1  clock, rising edge
//   rst          in  1  asynchronous active-high reset
//   alu_valid    in  1  ALU result present this cycle
//   alu_op       in  4  ALU opcode (selects the flag write mask)
//   alu_flag     in  3  ALU flags [N V Z]
//   br_valid     in  1  branch presented this cycle
//   br_cond      in  3  branch condition code
//   stall        in  1  freeze state; squashes this cycle's branch
//   flush        in  1  squash this cycle's ALU update and branch
//   flag         out 3  architectural flags [N V Z] (registered)
//   br_resolved  out 1  branch accepted on the previous edge (registered)
//   br_taken     out 1  branch outcome, meaningful while br_resolved=1
//   br_hazard    out 1  combinational; branch cannot resolve this cycle
// -----------------------------------------------------------------------------
module flag_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic [3:0] alu_op,
    input  logic [2:0] alu_flag,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    input  logic       stall,
    input  logic       flush,
    output logic [2:0] flag,
    output logic       br_resolved,
    output logic       br_taken,
    output logic       br_hazard
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    localparam logic [2:0] CC_NEQ    = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Which flag bits [N V Z] an opcode is allowed to write.
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

    // Branch condition evaluated on a flag vector f = [N V Z].
    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
        logic n;
        logic v;
        logic z;
        logic t;
        n = f[2];
        v = f[1];
        z = f[0];
        case (cc)
            CC_NEQ:    t = ~z;
            CC_EQ:     t = z;
            CC_GT:     t = ~z & ~n;
            CC_LT:     t = n;
            CC_GTE:    t = z | (~z & ~n);
            CC_LTE:    t = n | z;
            CC_OVFL:   t = v;
            CC_UNCOND: t = 1'b1;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    logic [2:0] flag_r;
    logic       br_resolved_r;
    logic       br_taken_r;

    logic [2:0] op_mask_s;
    logic       alu_write_s;
    logic [2:0] wr_mask_s;
    logic [2:0] next_flag_s;
    logic [2:0] cond_src_s;
    logic       br_hazard_s;
    logic       br_accept_s;
    logic       br_taken_d_s;

    // Flag write qualification and masked merge into the architectural flags.
    always_comb begin
        op_mask_s   = flag_mask(alu_op);
        alu_write_s = alu_valid & ~stall & ~flush & (op_mask_s != 3'b000);
        if (alu_write_s) begin
            wr_mask_s = op_mask_s;
        end else begin
            wr_mask_s = 3'b000;
        end
        next_flag_s = (flag_r & ~wr_mask_s) | (alu_flag & wr_mask_s);
    end

`ifdef FLAG_BYPASS_EN
    // Forwarding: the older same-cycle ALU op is visible to the branch.
    always_comb begin
        cond_src_s  = next_flag_s;
        br_hazard_s = 1'b0;
    end
`else
    // No forwarding: a branch colliding with a flag write must be re-presented.
    always_comb begin
        cond_src_s  = flag_r;
        br_hazard_s = br_valid & alu_write_s;
    end
`endif

    // Branch acceptance and the outcome to be registered.
    always_comb begin
        br_accept_s = br_valid & ~stall & ~flush & ~br_hazard_s;
        if (br_accept_s) begin
            br_taken_d_s = cond_eval(br_cond, cond_src_s);
        end else begin
            br_taken_d_s = 1'b0;
        end
    end

    // Architectural flag register; next_flag_s already equals flag_r when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_r <= 3'b000;
        end else begin
            flag_r <= next_flag_s;
        end
    end

    // Branch resolution register; any non-accepting cycle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_resolved_r <= 1'b0;
            br_taken_r    <= 1'b0;
        end else begin
            br_resolved_r <= br_accept_s;
            br_taken_r    <= br_taken_d_s;
        end
    end

    assign flag        = flag_r;
    assign br_resolved = br_resolved_r;
    assign br_taken    = br_taken_r;
    assign br_hazard   = br_hazard_s;

endmodule

// File: tb/tb_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_unit
//
// Directed self-checking bench for flag_unit. Inputs change 1 time unit after
// a rising edge; registered outputs are sampled at that same point and the
// combinational br_hazard is sampled before the edge. Builds with or without
// FLAG_BYPASS_EN; the collision scenarios branch on the macro.
// -----------------------------------------------------------------------------
module tb_flag_unit;

    logic       clk;
    logic       rst;
    logic       alu_valid;
    logic [3:0] alu_op;
    logic [2:0] alu_flag;
    logic       br_valid;
    logic [2:0] br_cond;
    logic       stall;
    logic       flush;
    logic [2:0] flag;
    logic       br_resolved;
    logic       br_taken;
    logic       br_hazard;

    int total;
    int bad;

    flag_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .alu_flag    (alu_flag),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .stall       (stall),
        .flush       (flush),
        .flag        (flag),
        .br_resolved (br_resolved),
        .br_taken    (br_taken),
        .br_hazard   (br_hazard)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_op    = 4'b1111;
        alu_flag  = 3'b000;
        br_valid  = 1'b0;
        br_cond   = 3'b000;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drive(input logic av, input logic [3:0] op, input logic [2:0] af,
                         input logic bv, input logic [2:0] cc,
                         input logic st, input logic fl);
        alu_valid = av;
        alu_op    = op;
        alu_flag  = af;
        br_valid  = bv;
        br_cond   = cc;
        stall     = st;
        flush     = fl;
    endtask

    // Advance one edge, sample just after it, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flag", flag, 3'b000);
        check("reset_resolved", {2'b00, br_resolved}, 3'b000);
        check("reset_taken", {2'b00, br_taken}, 3'b000);
        rst = 1'b0;

        // Load flags 111, then resolve UNCOND so a resolution is pending.
        drive(1'b1, 4'b0000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("add_111_flag", flag, 3'b111);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
        tick();
        check("uncond_resolved", {2'b00, br_resolved}, 3'b001);
        check("uncond_taken", {2'b00, br_taken}, 3'b001);

        // Mid-cycle asynchronous reset, no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("async_rst_flag", flag, 3'b000);
        check("async_rst_resolved", {2'b00, br_resolved}, 3'b000);
        check("async_rst_taken", {2'b00, br_taken}, 3'b000);
        #1 rst = 1'b0;
        tick();
        check("post_rst_no_pulse", {2'b00, br_resolved}, 3'b000);

        // SUB 110, then EQ (not taken), then OVFL (taken) back to back.
        drive(1'b1, 4'b0001, 3'b110, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("sub_110_flag", flag, 3'b110);
        check("sub_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        check("eq_resolved", {2'b00, br_resolved}, 3'b001);
        check("eq_taken", {2'b00, br_taken}, 3'b000);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b110, 1'b0, 1'b0);
        tick();
        check("ovfl_resolved", {2'b00, br_resolved}, 3'b001);
        check("ovfl_taken", {2'b00, br_taken}, 3'b001);
        tick();
        check("idle_clears_resolved", {2'b00, br_resolved}, 3'b000);
        check("idle_clears_taken", {2'b00, br_taken}, 3'b000);

        // Z-only write via XOR, then a non-writing opcode.
        drive(1'b1, 4'b0010, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("xor_z_only", flag, 3'b111);
        drive(1'b1, 4'b0111, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("op0111_no_write", flag, 3'b111);
        drive(1'b1, 4'b0110, 3'b110, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("ror_clears_z_only", flag, 3'b110);

        // Clear to 000, then ADD 001 together with EQ.
        drive(1'b1, 4'b0000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        check("add_000_flag", flag, 3'b000);
        drive(1'b1, 4'b0000, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0);
        #1;
`ifdef FLAG_BYPASS_EN
        check("collide_hazard", {2'b00, br_hazard}, 3'b000);
        tick();
        check("collide_flag", flag, 3'b001);
        check("bypass_resolved", {2'b00, br_resolved}, 3'b001);
        check("bypass_taken", {2'b00, br_taken}, 3'b001);
`else
        check("collide_hazard", {2'b00, br_hazard}, 3'b001);
        tick();
        check("collide_flag", flag, 3'b001);
        check("hazard_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0);
        #1;
        check("represent_no_hazard", {2'b00, br_hazard}, 3'b000);
        tick();
        check("represent_resolved", {2'b00, br_resolved}, 3'b001);
        check("represent_taken", {2'b00, br_taken}, 3'b001);
`endif

        // Stall with SUB 100 and GT: nothing changes, hazard forced low.
        drive(1'b1, 4'b0001, 3'b100, 1'b1, 3'b010, 1'b1, 1'b0);
        #1;
        check("stall_hazard", {2'b00, br_hazard}, 3'b000);
        tick();
        check("stall_flag_hold", flag, 3'b001);
        check("stall_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b1, 4'b0001, 3'b100, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        check("unstall_flag", flag, 3'b100);
`ifdef FLAG_BYPASS_EN
        check("unstall_gt_resolved", {2'b00, br_resolved}, 3'b001);
        check("unstall_gt_taken", {2'b00, br_taken}, 3'b000);
`else
        check("unstall_hazard_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        check("gt_resolved", {2'b00, br_resolved}, 3'b001);
        check("gt_taken", {2'b00, br_taken}, 3'b000);
`endif

        // Remaining conditions against flags 100 (N=1, V=0, Z=0).
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        check("neq_taken", {2'b00, br_taken}, 3'b001);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b011, 1'b0, 1'b0);
        tick();
        check("lt_taken", {2'b00, br_taken}, 3'b001);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0);
        tick();
        check("gte_taken", {2'b00, br_taken}, 3'b000);
        check("gte_resolved", {2'b00, br_resolved}, 3'b001);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b101, 1'b0, 1'b0);
        tick();
        check("lte_taken", {2'b00, br_taken}, 3'b001);

        // Flush with ADD and UNCOND, then flush+stall, then UNCOND alone.
        drive(1'b1, 4'b0000, 3'b001, 1'b1, 3'b111, 1'b0, 1'b1);
        #1;
        check("flush_hazard", {2'b00, br_hazard}, 3'b000);
        tick();
        check("flush_flag_hold", flag, 3'b100);
        check("flush_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b1, 4'b0000, 3'b011, 1'b1, 3'b111, 1'b1, 1'b1);
        tick();
        check("flush_stall_flag_hold", flag, 3'b100);
        check("flush_stall_no_resolve", {2'b00, br_resolved}, 3'b000);
        drive(1'b0, 4'b1111, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
        tick();
        check("post_flush_resolved", {2'b00, br_resolved}, 3'b001);
        check("post_flush_taken", {2'b00, br_taken}, 3'b001);
        check("branch_keeps_flag", flag, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
